// File: rtl/afifo_pkg.sv
// Shared definitions for the async FIFO and its read-side stream adapter.
package afifo_pkg;
  localparam int AFIFO_WIDTH = 8;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  typedef enum logic [1:0] {
    ST_EMPTY = OCC_EMPTY,
    ST_ONE   = OCC_ONE,
    ST_TWO   = OCC_TWO
  } occ_e;
endpackage

// File: rtl/afifo_rd_stream.sv
// Read-side consumer of the async FIFO: pops words into a 2-entry skid buffer and
// re-presents them as a registered valid/ready stream with a delivered-word counter.
module afifo_rd_stream
  import afifo_pkg::*;
#(
  parameter int WIDTH = AFIFO_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk_r,
  input  logic             rst_r,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             fifo_pop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] word_count
);

  occ_e             r_state;
  occ_e             w_state_nxt;
  logic [WIDTH-1:0] r_slot0;
  logic [WIDTH-1:0] r_slot1;
  logic [WIDTH-1:0] w_slot0_nxt;
  logic [WIDTH-1:0] w_slot1_nxt;
  logic [CNT_W-1:0] r_wc;
  logic             w_push;
  logic             w_take;

  // Pop depends only on registered occupancy, so out_ready never reaches fifo_pop.
  assign w_push = ~rst_r & ~fifo_empty & (r_state != ST_TWO);
  assign w_take = (r_state != ST_EMPTY) & out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_slot0_nxt = r_slot0;
    w_slot1_nxt = r_slot1;
    case (r_state)
      ST_EMPTY: begin
        if (w_push) begin
          w_state_nxt = ST_ONE;
          w_slot0_nxt = fifo_rdata;
        end
      end
      ST_ONE: begin
        if (w_push && w_take) begin
          w_slot0_nxt = fifo_rdata;
        end else if (w_push) begin
          w_state_nxt = ST_TWO;
          w_slot1_nxt = fifo_rdata;
        end else if (w_take) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // Skid slot moves to the head once the downstream takes the oldest word.
        if (w_take) begin
          w_state_nxt = ST_ONE;
          w_slot0_nxt = r_slot1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk_r) begin
    if (rst_r) begin
      r_state <= ST_EMPTY;
      r_slot0 <= '0;
      r_slot1 <= '0;
      r_wc    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_slot0 <= w_slot0_nxt;
      r_slot1 <= w_slot1_nxt;
      if (w_take) begin
        r_wc <= r_wc + CNT_W'(1);
      end
    end
  end

  assign fifo_pop   = w_push;
  assign out_valid  = (r_state != ST_EMPTY);
  assign out_data   = r_slot0;
  assign occupancy  = r_state;
  assign word_count = r_wc;

endmodule

// File: tb/tb_afifo_rd_stream.sv
// Bench for afifo_rd_stream: queue-based FIFO stand-in on a separate write clock,
// scoreboard of written words and a negedge monitor comparing the stream.
`timescale 1ns/100ps
module tb_afifo_rd_stream;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk_r = 1'b0;
  logic             clk_w = 1'b0;
  logic             rst_r = 1'b1;
  logic             out_ready = 1'b0;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_rdata;
  logic             fifo_pop;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] word_count;

  logic [WIDTH-1:0] fifoq[$];
  logic [WIDTH-1:0] expq[$];

  int checks = 0;
  int errors = 0;
  int inflight = 0;
  int wc_model = 0;
  int pop_cnt = 0;
  int valid_cnt = 0;
  int take_cnt = 0;
  int cyc_no = 0;
  int first_take = -1;
  int last_take = -1;
  int max_occ = 0;
  bit mon_en = 1'b0;
  bit hold_prev = 1'b0;
  logic [WIDTH-1:0] hold_data = '0;

  afifo_rd_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk_r      (clk_r),
    .rst_r      (rst_r),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_pop   (fifo_pop),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .occupancy  (occupancy),
    .word_count (word_count)
  );

  always #5 clk_r = ~clk_r;

  // Write clock edges fall on half-ns times so they never coincide with read-side events.
  initial begin
    #2.5;
    forever begin
      clk_w = 1'b1;
      #7;
      clk_w = 1'b0;
      #7;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic update_view();
    fifo_empty = (fifoq.size() == 0);
    fifo_rdata = fifo_empty ? '0 : fifoq[0];
  endtask

  task automatic cyc();
    @(posedge clk_r);
    #1;
  endtask

  task automatic write_word(input logic [WIDTH-1:0] v);
    @(posedge clk_w);
    fifoq.push_back(v);
    expq.push_back(v);
    update_view();
  endtask

  task automatic wait_drain(input int maxc);
    int n;
    n = 0;
    while ((expq.size() != 0 || fifoq.size() != 0) && n < maxc) begin
      cyc();
      n++;
    end
    if (expq.size() != 0 || fifoq.size() != 0) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  // Reference model: FIFO pops, words held downstream of the FIFO, delivered-word count.
  always @(posedge clk_r) begin
    logic p, t, r, v;
    logic [1:0] occ;
    p = fifo_pop;
    v = out_valid;
    t = out_valid && out_ready && !rst_r;
    r = rst_r;
    occ = occupancy;
    #1;
    cyc_no++;
    if (p === 1'b1) begin
      pop_cnt++;
      if (fifoq.size() > 0) void'(fifoq.pop_front());
      update_view();
    end
    if (v === 1'b1) valid_cnt++;
    if (t === 1'b1) begin
      take_cnt++;
      if (first_take < 0) first_take = cyc_no;
      last_take = cyc_no;
    end
    if (int'(occ) > max_occ) max_occ = int'(occ);
    if (r === 1'b1) begin
      repeat (inflight) if (expq.size() > 0) void'(expq.pop_front());
      inflight = 0;
      wc_model = 0;
    end else begin
      inflight = inflight + int'(p === 1'b1) - int'(t === 1'b1);
      if (t === 1'b1) wc_model = (wc_model + 1) % (1 << CNT_W);
    end
  end

  // Monitor: compares the stream against the scoreboard every cycle.
  always @(negedge clk_r) begin
    if (mon_en) begin
      chk("occupancy", 32'(occupancy), 32'(inflight));
      chk("out_valid", 32'(out_valid), 32'(inflight != 0));
      chk("word_count", 32'(word_count), 32'(wc_model));
      chk("fifo_pop", 32'(fifo_pop), 32'(!rst_r && !fifo_empty && inflight != 2));
      if (hold_prev) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(hold_data));
      end
      if (out_valid && out_ready && !rst_r) begin
        if (expq.size() == 0) chk("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
        else chk("out_data", 32'(out_data), 32'(expq.pop_front()));
      end
      hold_prev = out_valid && !out_ready && !rst_r;
      hold_data = out_data;
    end
  end

  initial begin
    update_view();
    repeat (3) cyc();
    @(negedge clk_r);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    mon_en = 1'b1;

    // Single word
    cyc();
    rst_r = 1'b0;
    out_ready = 1'b1;
    pop_cnt = 0;
    valid_cnt = 0;
    write_word(8'h11);
    repeat (8) cyc();
    chk("single_pops", 32'(pop_cnt), 32'd1);
    chk("single_valid_cycles", 32'(valid_cnt), 32'd1);
    @(negedge clk_r);
    chk("single_word_count", 32'(word_count), 32'd1);

    // Burst preloaded under reset, then streamed; counter wraps 15 -> 0 on the 16th word
    cyc();
    rst_r = 1'b1;
    for (int i = 0; i < 16; i++) write_word(8'(i));
    cyc();
    take_cnt = 0;
    first_take = -1;
    max_occ = 0;
    rst_r = 1'b0;
    wait_drain(100);
    cyc();
    chk("burst_words", 32'(take_cnt), 32'd16);
    chk("burst_back_to_back", 32'(last_take - first_take), 32'd15);
    chk("burst_max_occ_le1", 32'(max_occ <= 1), 32'd1);
    @(negedge clk_r);
    chk("burst_wc_wrap", 32'(word_count), 32'd0);

    // Backpressure with three words waiting
    cyc();
    out_ready = 1'b0;
    write_word(8'hA1);
    write_word(8'hA2);
    write_word(8'hA3);
    repeat (6) cyc();
    @(negedge clk_r);
    chk("bp_occupancy", 32'(occupancy), 32'd2);
    chk("bp_fifo_pop", 32'(fifo_pop), 32'd0);
    chk("bp_out_data", 32'(out_data), 32'hA1);
    cyc();
    out_ready = 1'b1;
    wait_drain(50);

    // Reset while the skid buffer is full
    cyc();
    out_ready = 1'b0;
    write_word(8'hB1);
    write_word(8'hB2);
    write_word(8'hB3);
    repeat (6) cyc();
    @(negedge clk_r);
    chk("prerst_occupancy", 32'(occupancy), 32'd2);
    cyc();
    rst_r = 1'b1;
    cyc();
    rst_r = 1'b0;
    @(negedge clk_r);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_occupancy", 32'(occupancy), 32'd0);
    chk("midrst_word_count", 32'(word_count), 32'd0);
    repeat (3) cyc();
    @(negedge clk_r);
    chk("postrst_out_data", 32'(out_data), 32'hB3);
    cyc();
    out_ready = 1'b1;
    wait_drain(50);

    // Random writes against random backpressure
    cyc();
    take_cnt = 0;
    begin
      bit wdone;
      wdone = 1'b0;
      fork
        begin
          for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk_w);
            write_word(8'($urandom));
          end
          wdone = 1'b1;
        end
        begin
          while (!wdone) begin
            cyc();
            out_ready = 1'($urandom_range(0, 1));
          end
        end
      join
    end
    cyc();
    out_ready = 1'b1;
    wait_drain(200);
    cyc();
    chk("random_words", 32'(take_cnt), 32'd1000);

    repeat (2) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
